// File: rtl/operand_pair_ram_if.sv
// ---------------------------------------------------------------------------
// operand_pair_ram_if
// Bus bundle between the memory controller (master) and the dual-operand RAM
// (slave). Clock and reset stay outside the bundle as plain ports.
//   mem_we / mem_wr_mask / mem_wr_addr / mem_data_in_op{a,b} : shared write port
//   mem_rd_en / mem_rd_addr_op{a,b}                          : paired read request
//   mem_data_out_op{a,b} / mem_rd_valid                      : read response
//   mem_ready                                                : block accepting traffic
// ---------------------------------------------------------------------------
interface operand_pair_ram_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 6
);

  logic              mem_we;
  logic [1:0]        mem_wr_mask;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_data_in_opa;
  logic [DATA_W-1:0] mem_data_in_opb;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr_opa;
  logic [ADDR_W-1:0] mem_rd_addr_opb;
  logic [DATA_W-1:0] mem_data_out_opa;
  logic [DATA_W-1:0] mem_data_out_opb;
  logic              mem_rd_valid;
  logic              mem_ready;

  // Requester side: memory controller / execution-unit front end
  modport master (
    output mem_we, mem_wr_mask, mem_wr_addr, mem_data_in_opa, mem_data_in_opb,
    output mem_rd_en, mem_rd_addr_opa, mem_rd_addr_opb,
    input  mem_data_out_opa, mem_data_out_opb, mem_rd_valid, mem_ready
  );

  // Storage side: operand_pair_ram
  modport slave (
    input  mem_we, mem_wr_mask, mem_wr_addr, mem_data_in_opa, mem_data_in_opb,
    input  mem_rd_en, mem_rd_addr_opa, mem_rd_addr_opb,
    output mem_data_out_opa, mem_data_out_opb, mem_rd_valid, mem_ready
  );

endinterface : operand_pair_ram_if

// File: rtl/operand_pair_ram.sv
// ---------------------------------------------------------------------------
// operand_pair_ram
// Two parallel operand banks (OPA, OPB) sharing one write address, with
// independent read addresses, registered reads (RD_LAT = 1 or 2), a one-cycle
// valid strobe per accepted read and write-first forwarding per bank.
// With CLEAR_ON_RST = 1 a post-reset sweep zeroes both banks over DEPTH
// cycles while mem_ready is low.
// Ports:
//   mem_clk : clock, rising edge
//   mem_rst : synchronous reset, active-high
//   bus     : operand_pair_ram_if slave modport (write, read, response, ready)
// ---------------------------------------------------------------------------
module operand_pair_ram #(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned RD_LAT       = 1,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input  logic                     mem_clk,
  input  logic                     mem_rst,
  operand_pair_ram_if.slave        bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              ready_q;

  logic [DATA_W-1:0] opa_mem [DEPTH];
  logic [DATA_W-1:0] opb_mem [DEPTH];

  // Qualified request strobes; nothing is accepted while reset is asserted
  logic              clearing_c;
  logic              wr_ok_c;
  logic              rd_ok_c;
  logic              wr_opa_c;
  logic              wr_opb_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_opa_c;
  logic [DATA_W-1:0] wr_data_opb_c;
  logic [DATA_W-1:0] rd_opa_c;
  logic [DATA_W-1:0] rd_opb_c;

  // First read stage: captured at the sampling edge, holds when idle
  logic              s1_vld_q;
  logic [DATA_W-1:0] s1_opa_q;
  logic [DATA_W-1:0] s1_opb_q;

  // Control FSM: clear sweep then ready; reset restarts the sweep from 0
  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      state_q    <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
      clr_addr_q <= '0;
      ready_q    <= ~CLEAR_ON_RST;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + ADDR_W'(1);
          if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign clearing_c = ~mem_rst & (state_q == ST_CLEAR);
  assign wr_ok_c    = ~mem_rst & (state_q == ST_READY) & bus.mem_we;
  assign rd_ok_c    = ~mem_rst & (state_q == ST_READY) & bus.mem_rd_en;

  // Write port mux: clear sweep zero-writes both banks, else masked user write
  always_comb begin
    wr_opa_c      = 1'b0;
    wr_opb_c      = 1'b0;
    wr_addr_c     = bus.mem_wr_addr;
    wr_data_opa_c = bus.mem_data_in_opa;
    wr_data_opb_c = bus.mem_data_in_opb;
    if (clearing_c) begin
      wr_opa_c      = 1'b1;
      wr_opb_c      = 1'b1;
      wr_addr_c     = clr_addr_q;
      wr_data_opa_c = '0;
      wr_data_opb_c = '0;
    end else if (wr_ok_c) begin
      wr_opa_c = bus.mem_wr_mask[0];
      wr_opb_c = bus.mem_wr_mask[1];
    end
  end

  // Storage arrays: no reset, contents only defined through the clear sweep
  always_ff @(posedge mem_clk) begin
    if (wr_opa_c) begin
      opa_mem[wr_addr_c] <= wr_data_opa_c;
    end
    if (wr_opb_c) begin
      opb_mem[wr_addr_c] <= wr_data_opb_c;
    end
  end

  // Write-first: each bank forwards a same-cycle masked write to its own read address
  always_comb begin
    rd_opa_c = opa_mem[bus.mem_rd_addr_opa];
    rd_opb_c = opb_mem[bus.mem_rd_addr_opb];
    if (wr_ok_c && bus.mem_wr_mask[0] && (bus.mem_wr_addr == bus.mem_rd_addr_opa)) begin
      rd_opa_c = bus.mem_data_in_opa;
    end
    if (wr_ok_c && bus.mem_wr_mask[1] && (bus.mem_wr_addr == bus.mem_rd_addr_opb)) begin
      rd_opb_c = bus.mem_data_in_opb;
    end
  end

  // Read stage 1: data is frozen at the sampling edge, later writes cannot alter it
  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      s1_vld_q <= 1'b0;
      s1_opa_q <= '0;
      s1_opb_q <= '0;
    end else begin
      s1_vld_q <= rd_ok_c;
      if (rd_ok_c) begin
        s1_opa_q <= rd_opa_c;
        s1_opb_q <= rd_opb_c;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              out_vld_q;
      logic [DATA_W-1:0] out_opa_q;
      logic [DATA_W-1:0] out_opb_q;

      // Second stage: forwards stage-1 results, holding last data when idle
      always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
          out_vld_q <= 1'b0;
          out_opa_q <= '0;
          out_opb_q <= '0;
        end else begin
          out_vld_q <= s1_vld_q;
          if (s1_vld_q) begin
            out_opa_q <= s1_opa_q;
            out_opb_q <= s1_opb_q;
          end
        end
      end

      assign bus.mem_rd_valid     = out_vld_q;
      assign bus.mem_data_out_opa = out_opa_q;
      assign bus.mem_data_out_opb = out_opb_q;
    end else begin : g_lat1
      assign bus.mem_rd_valid     = s1_vld_q;
      assign bus.mem_data_out_opa = s1_opa_q;
      assign bus.mem_data_out_opb = s1_opb_q;
    end
  endgenerate

  assign bus.mem_ready = ready_q;

endmodule : operand_pair_ram

// File: tb/tb_operand_pair_ram.sv
// ---------------------------------------------------------------------------
// tb_operand_pair_ram
// Drives identical traffic into an RD_LAT=1 and an RD_LAT=2 instance. A
// behavioural model (plain arrays) computes expected read results, which are
// queued per instance; monitors pop and compare on every valid strobe.
// ---------------------------------------------------------------------------
module tb_operand_pair_ram;

  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef struct packed {
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
  } rd_exp_t;

  logic mem_clk;
  logic mem_rst;

  operand_pair_ram_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  operand_pair_ram_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

  operand_pair_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CLEAR_ON_RST(1'b1)) u_lat1 (
    .mem_clk (mem_clk),
    .mem_rst (mem_rst),
    .bus     (if1.slave)
  );

  operand_pair_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RST(1'b1)) u_lat2 (
    .mem_clk (mem_clk),
    .mem_rst (mem_rst),
    .bus     (if2.slave)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] ma [DEPTH];
  logic [DW-1:0] mb [DEPTH];
  int            since_rst = 0;
  rd_exp_t       q1 [$];
  rd_exp_t       q2 [$];
  rd_exp_t       pend;
  bit            pend_v = 1'b0;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock of stimulus; the model then advances with the same edge
  task automatic step(input logic rst, input logic we, input logic [1:0] mask,
                      input logic [AW-1:0] wa, input logic [DW-1:0] da, input logic [DW-1:0] db,
                      input logic re, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    rd_exp_t e;
    bit live;
    mem_rst = rst;
    if1.mem_we = we;  if1.mem_wr_mask = mask;  if1.mem_wr_addr = wa;
    if1.mem_data_in_opa = da;  if1.mem_data_in_opb = db;
    if1.mem_rd_en = re;  if1.mem_rd_addr_opa = ra;  if1.mem_rd_addr_opb = rb;
    if2.mem_we = we;  if2.mem_wr_mask = mask;  if2.mem_wr_addr = wa;
    if2.mem_data_in_opa = da;  if2.mem_data_in_opb = db;
    if2.mem_rd_en = re;  if2.mem_rd_addr_opa = ra;  if2.mem_rd_addr_opb = rb;
    @(posedge mem_clk);
    if (rst) begin
      pend_v    = 1'b0;
      since_rst = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ma[i] = '0;
        mb[i] = '0;
      end
    end else begin
      live = (since_rst >= int'(DEPTH));
      if (pend_v) begin
        q2.push_back(pend);
        pend_v = 1'b0;
      end
      if (live && re) begin
        e.opa = (we && mask[0] && wa == ra) ? da : ma[ra];
        e.opb = (we && mask[1] && wa == rb) ? db : mb[rb];
        q1.push_back(e);
        pend   = e;
        pend_v = 1'b1;
      end
      if (live && we) begin
        if (mask[0]) ma[wa] = da;
        if (mask[1]) mb[wa] = db;
      end
      since_rst++;
    end
    #1;
    chk("ready_lat1", DW'(if1.mem_ready), DW'(!rst && since_rst >= int'(DEPTH)));
    chk("ready_lat2", DW'(if2.mem_ready), DW'(!rst && since_rst >= int'(DEPTH)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b1, ra, rb);
  endtask

  task automatic wr(input logic [1:0] mask, input logic [AW-1:0] wa,
                    input logic [DW-1:0] da, input logic [DW-1:0] db);
    step(1'b0, 1'b1, mask, wa, da, db, 1'b0, '0, '0);
  endtask

  task automatic check_flushed(input string tag);
    chk({tag, "_valid1"}, DW'(if1.mem_rd_valid), '0);
    chk({tag, "_valid2"}, DW'(if2.mem_rd_valid), '0);
    chk({tag, "_opa1"}, if1.mem_data_out_opa, '0);
    chk({tag, "_opb1"}, if1.mem_data_out_opb, '0);
    chk({tag, "_opa2"}, if2.mem_data_out_opa, '0);
    chk({tag, "_opb2"}, if2.mem_data_out_opb, '0);
  endtask

  // Monitors: every valid strobe must match the oldest outstanding expectation
  always @(negedge mem_clk) begin
    rd_exp_t e;
    if (if1.mem_rd_valid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL lat1_unexpected_valid got=1 exp=0");
      end else begin
        e = q1.pop_front();
        chk("lat1_opa", if1.mem_data_out_opa, e.opa);
        chk("lat1_opb", if1.mem_data_out_opb, e.opb);
      end
    end
  end

  always @(negedge mem_clk) begin
    rd_exp_t e;
    if (if2.mem_rd_valid === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL lat2_unexpected_valid got=1 exp=0");
      end else begin
        e = q2.pop_front();
        chk("lat2_opa", if2.mem_data_out_opa, e.opa);
        chk("lat2_opb", if2.mem_data_out_opb, e.opb);
      end
    end
  end

  initial begin
    logic [DW-1:0] pat_a;
    logic [DW-1:0] pat_b;
    pat_a = {16{8'hA5}};
    pat_b = {16{8'h5A}};

    // Reset, then the 64-cycle clear sweep with ready low throughout
    step(1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b0, '0, '0);
    check_flushed("reset");
    idle(int'(DEPTH) + 2);

    // Top address reads back zero after the sweep
    rd(6'd63, 6'd63);
    idle(3);

    // Plain write then read of both banks
    wr(2'b11, 6'd5, pat_a, pat_b);
    rd(6'd5, 6'd5);
    idle(3);

    // Write-first on OPA only; OPB returns old data
    wr(2'b11, 6'd9, DW'(1), DW'(2));
    step(1'b0, 1'b1, 2'b01, 6'd9, DW'(7), DW'(99), 1'b1, 6'd9, 6'd9);
    idle(3);

    // Back-to-back reads of freshly written addresses 0..3
    for (int i = 0; i < 4; i++) wr(2'b11, AW'(i), rnd128(), rnd128());
    for (int i = 0; i < 4; i++) rd(AW'(i), AW'(i));
    idle(3);

    // Randomized mixed traffic, small address window to provoke collisions
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)),
           rnd128(), rnd128(), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    idle(3);

    // Reset 30 cycles into a clear sweep restarts it; writes during clear are ignored
    step(1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 2'b11, AW'($urandom_range(0, 63)),
           rnd128(), rnd128(), 1'($urandom_range(0, 1)), '0, '0);
    end
    step(1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 2'b11, AW'($urandom_range(0, 63)),
           rnd128(), rnd128(), 1'($urandom_range(0, 1)), '0, '0);
    end
    idle(3);
    for (int i = 0; i < int'(DEPTH); i++) rd(AW'(i), AW'(DEPTH - 1 - i));
    idle(3);

    // Read in flight when reset arrives: the two-cycle instance must drop it
    wr(2'b11, 6'd3, rnd128(), rnd128());
    rd(6'd3, 6'd3);
    step(1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b0, '0, '0);
    check_flushed("rst_inflight");
    idle(int'(DEPTH) + 4);

    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      failures++;
      $display("FAIL outstanding_reads got=%0d/%0d exp=0/0", q1.size(), q2.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_operand_pair_ram

// File: doc/operand_pair_ram.md
Name: operand_pair_ram

Overview:
Parametrised dual-operand storage for the datapath. Two parallel banks (OPA, OPB) share one write address and have independent read addresses. Reads are registered with a configurable read latency, a valid strobe and write-first forwarding. An optional post-reset clear sweep zeroes both banks. It supersedes the fixed 64x128 combinational-read operand RAM between the memory controller and the execution units.

Parameters:
DATA_W, 128, width of each operand word
ADDR_W, 6, address width; depth DEPTH = 2**ADDR_W (derived, not overridable)
RD_LAT, 1, read latency in cycles; legal values 1 or 2
CLEAR_ON_RST, 1, 1 = zero both banks after reset; 0 = contents undefined after reset

Ports:
mem_clk  input  1  clock, all logic on rising edge
mem_rst  input  1  synchronous reset, active-high
mem_we  input  1  write strobe
mem_wr_mask  input  2  bit0 = write OPA bank, bit1 = write OPB bank
mem_wr_addr  input  ADDR_W  write address, common to both banks
mem_data_in_opa  input  DATA_W  OPA write data
mem_data_in_opb  input  DATA_W  OPB write data
mem_rd_en  input  1  read request
mem_rd_addr_opa  input  ADDR_W  OPA read address
mem_rd_addr_opb  input  ADDR_W  OPB read address
mem_data_out_opa  output  DATA_W  OPA read data
mem_data_out_opb  output  DATA_W  OPB read data
mem_rd_valid  output  1  read data valid, one pulse per accepted read
mem_ready  output  1  high when the block accepts reads and writes

Behaviour:
- One clock (mem_clk). Reset is synchronous and active-high (mem_rst).
- Reset values: mem_data_out_opa/opb = 0, mem_rd_valid = 0, read pipeline flushed. mem_ready = 0 if CLEAR_ON_RST = 1, otherwise 1 from the first cycle after reset.
- FSM has two states, CLEAR and READY.
  - Reset enters CLEAR when CLEAR_ON_RST = 1, otherwise READY.
  - CLEAR: counter clr_addr starts at 0. Each cycle writes 0 to both banks at clr_addr, then increments.
  - At clr_addr = DEPTH-1, the zero write occurs and the FSM moves to READY next cycle. The clear lasts exactly DEPTH cycles with mem_ready = 0.
  - Reset asserted mid-clear restarts the sweep at clr_addr = 0.
- In CLEAR, mem_we and mem_rd_en are ignored: no write, no valid, no queuing.
- Write (READY, mem_we = 1): at the clock edge, bank OPA[mem_wr_addr] <= mem_data_in_opa if mem_wr_mask[0]. Bank OPB[mem_wr_addr] <= mem_data_in_opb if mem_wr_mask[1]. mask = 0 means no-op.
- Read (READY, mem_rd_en = 1): sampled at edge N.
  - RD_LAT = 1: data and mem_rd_valid = 1 are presented after edge N.
  - RD_LAT = 2: data and valid appear after edge N+1.
  - Back-to-back reads are fully pipelined, one result per cycle.
- mem_rd_valid is high for exactly one cycle per accepted read. Outputs hold the last read data when valid = 0.
- Write-first: if a read and a write in the same cycle hit the same address in a bank whose mask bit is set, that bank returns the new write data. A bank whose mask bit is clear returns old data.
  - Each bank compares independently against its own read address.
  - For RD_LAT = 2, forwarding applies only to a write in the read's sampling cycle. A write in the following cycle does not alter the in-flight result.
- Reads in flight when reset asserts are discarded: no valid emitted.
- Addresses are ADDR_W bits with no out-of-range case. No wrap logic is needed beyond natural width.

Test Plan:
- Reset, CLEAR_ON_RST = 1, ADDR_W = 6 -> mem_ready = 0 for 64 cycles, then 1. A read of addr 63 on OPA and OPB returns 0 with mem_rd_valid pulse.
- Write addr 5, mask = 2'b11, opa = 0xA5..A5, opb = 0x5A..5A. Read addr_opa = 5, addr_opb = 5 next cycle -> values returned after RD_LAT cycles, valid high 1 cycle.
- Pre-load addr 9 opa = 1, opb = 2. Same cycle: write addr 9 opa = 7, mask = 2'b01, and read both at 9 -> opa = 7 (forwarded), opb = 2 (old).
- RD_LAT = 2: reads to addrs 0,1,2,3 on consecutive cycles -> four consecutive valid cycles with matching data, starting 2 cycles after the first request.
- Assert mem_rst at clear cycle 30 -> mem_ready stays 0 for a further full 64 cycles. mem_we pulses during clear leave memory 0.
- Read issued, mem_rst asserted the next cycle (RD_LAT = 2) -> no mem_rd_valid pulse, outputs = 0.
